// File: rtl/avst_pkt_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avst_pkt_gen_pkg
// Brief    : Shared constants, FSM state encoding and beat record for
//            the Avalon-ST packet generator.
// Revision : 1.0
// ============================================================================
package avst_pkt_gen_pkg;

    localparam int c_SYMBOLS = 64;
    localparam int c_SYM_W   = 8;
    localparam int c_DATA_W  = c_SYMBOLS * c_SYM_W;
    localparam int c_EMPTY_W = 6;
    localparam int c_LEN_W   = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic                 sop;
        logic                 eop;
        logic [c_EMPTY_W-1:0] empty;
        logic                 error;
        logic [c_DATA_W-1:0]  data;
    } beat_t;

endpackage : avst_pkt_gen_pkg
`default_nettype wire

// File: rtl/avst_pkt_gen_beat_fmt.sv
`default_nettype none
// ============================================================================
// Module   : avst_pkt_gen_beat_fmt
// Brief    : Combinational beat formatter: incrementing-byte payload from
//            (base, rem), plus end-of-packet flag and empty count.
// Revision : 1.0
// ============================================================================
module avst_pkt_gen_beat_fmt
    import avst_pkt_gen_pkg::*;
(
    input  logic [c_SYM_W-1:0]   i_base,
    input  logic [c_LEN_W:0]     i_rem,
    output logic [c_DATA_W-1:0]  o_data,
    output logic                 o_eop,
    output logic [c_EMPTY_W-1:0] o_empty
);

    // Symbol 0 sits in the most significant byte; symbols past the end are zero.
    for (genvar gi = 0; gi < c_SYMBOLS; gi++) begin : g_sym
        localparam logic [c_LEN_W:0]   c_IDX = (c_LEN_W + 1)'(gi);
        localparam logic [c_SYM_W-1:0] c_OFF = c_SYM_W'(gi);
        assign o_data[c_DATA_W-1-gi*c_SYM_W -: c_SYM_W] =
            (i_rem > c_IDX) ? (i_base + c_OFF) : '0;
    end

    assign o_eop = (i_rem <= (c_LEN_W + 1)'(c_SYMBOLS));

    // 64 - rem modulo 64 is exactly the negated low bits; rem == 64 yields 0.
    assign o_empty = o_eop ? (c_EMPTY_W'(0) - i_rem[c_EMPTY_W-1:0]) : '0;

endmodule : avst_pkt_gen_beat_fmt
`default_nettype wire

// File: rtl/avst_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : avst_pkt_gen
// Brief    : Avalon-ST packet source. One command per packet, SOP/EOP/empty
//            framed beats of incrementing bytes under ready/valid backpressure.
//            Optional macro AVST_PKT_GEN_ERR_INJ_EN drives out_error on EOP.
// Revision : 1.0
// ============================================================================
module avst_pkt_gen
    import avst_pkt_gen_pkg::*;
#(
    parameter int SYMBOLS_PER_BEAT = 64,
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int EMPTY_WIDTH      = 6,
    parameter int LEN_WIDTH        = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [LEN_WIDTH-1:0]                    cmd_len,
    input  logic [7:0]                              cmd_seed,
    input  logic                                    cmd_err,
    input  logic                                    out_ready,
    output logic                                    out_valid,
    output logic                                    out_startofpacket,
    output logic                                    out_endofpacket,
    output logic [EMPTY_WIDTH-1:0]                  out_empty,
    output logic                                    out_error,
    output logic [SYMBOLS_PER_BEAT*BITS_PER_SYMBOL-1:0] out_data,
    output logic                                    busy,
    output logic [31:0]                             pkt_count
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_cmd_ready;
    logic                r_valid;
    beat_t               r_beat;
    logic [c_LEN_W:0]    r_rem;
    logic [c_SYM_W-1:0]  r_base;
    logic [31:0]         r_pkt_count;

    logic                w_cmd_fire;
    logic                w_start;
    logic                w_accept;
    logic                w_adv;
    logic                w_last;
    logic [c_SYM_W-1:0]  w_fmt_base;
    logic [c_LEN_W:0]    w_fmt_rem;
    logic [c_DATA_W-1:0] w_fmt_data;
    logic                w_fmt_eop;
    logic [c_EMPTY_W-1:0] w_fmt_empty;
    logic                w_beat_err;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_SEND;
            ST_SEND: if (w_last)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake strobes and formatter operand select. In IDLE the first beat
    // is built straight from the command; in SEND the following beat is built
    // one beat ahead so an accept never leaves a bubble.
    always_comb begin
        w_cmd_fire = r_cmd_ready & cmd_valid;
        w_start    = w_cmd_fire & (cmd_len != '0);
        w_accept   = r_valid & out_ready;
        w_adv      = w_accept & ~r_beat.eop;
        w_last     = w_accept & r_beat.eop;
        if (r_state == ST_IDLE) begin
            w_fmt_base = cmd_seed;
            w_fmt_rem  = {1'b0, cmd_len};
        end else begin
            w_fmt_base = r_base + c_SYM_W'(c_SYMBOLS);
            w_fmt_rem  = r_rem - (c_LEN_W + 1)'(c_SYMBOLS);
        end
    end

    avst_pkt_gen_beat_fmt u_beat_fmt (
        .i_base  (w_fmt_base),
        .i_rem   (w_fmt_rem),
        .o_data  (w_fmt_data),
        .o_eop   (w_fmt_eop),
        .o_empty (w_fmt_empty)
    );

`ifdef AVST_PKT_GEN_ERR_INJ_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_start) begin
            r_err <= cmd_err;
        end
    end

    assign w_beat_err = w_fmt_eop & ((r_state == ST_IDLE) ? cmd_err : r_err);
`else
    logic w_unused_cmd_err;
    assign w_unused_cmd_err = cmd_err;
    assign w_beat_err       = 1'b0;
`endif

    // Output register and packet bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_ready <= 1'b0;
            r_valid     <= 1'b0;
            r_beat      <= '0;
            r_rem       <= '0;
            r_base      <= '0;
            r_pkt_count <= '0;
        end else begin
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            if (w_start || w_adv) begin
                r_valid <= 1'b1;
                r_rem   <= w_fmt_rem;
                r_base  <= w_fmt_base;
                r_beat  <= '{sop:   w_start,
                             eop:   w_fmt_eop,
                             empty: w_fmt_empty,
                             error: w_beat_err,
                             data:  w_fmt_data};
            end else if (w_last) begin
                r_valid     <= 1'b0;
                r_beat      <= '0;
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    assign cmd_ready         = r_cmd_ready;
    assign out_valid         = r_valid;
    assign out_startofpacket = r_beat.sop;
    assign out_endofpacket   = r_beat.eop;
    assign out_empty         = r_beat.empty;
    assign out_error         = r_beat.error;
    assign out_data          = r_beat.data;
    assign busy              = (r_state == ST_SEND);
    assign pkt_count         = r_pkt_count;

endmodule : avst_pkt_gen
`default_nettype wire

// File: tb/tb_avst_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_avst_pkt_gen
// Brief    : Scoreboard bench for avst_pkt_gen: per-command expected beats are
//            queued at issue time and compared on every accepted beat.
// Revision : 1.0
// ============================================================================
module tb_avst_pkt_gen;

    typedef struct packed {
        logic         sop;
        logic         eop;
        logic [5:0]   empty;
        logic         error;
        logic [511:0] data;
    } exp_beat_t;

`ifdef AVST_PKT_GEN_ERR_INJ_EN
    localparam bit ERR_INJ = 1'b1;
`else
    localparam bit ERR_INJ = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [15:0]  cmd_len = '0;
    logic [7:0]   cmd_seed = '0;
    logic         cmd_err = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic         out_startofpacket;
    logic         out_endofpacket;
    logic [5:0]   out_empty;
    logic         out_error;
    logic [511:0] out_data;
    logic         busy;
    logic [31:0]  pkt_count;

    int        n_checks   = 0;
    int        n_errors   = 0;
    int        acc_count  = 0;
    int        ready_mode = 0;
    int        exp_pkts   = 0;
    exp_beat_t sb[$];

    always #5 clk = ~clk;

    avst_pkt_gen dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_len           (cmd_len),
        .cmd_seed          (cmd_seed),
        .cmd_err           (cmd_err),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .out_error         (out_error),
        .out_data          (out_data),
        .busy              (busy),
        .pkt_count         (pkt_count)
    );

    task automatic chk_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference packet model: builds every beat independently from len/seed.
    function automatic void push_pkt(input int len, input logic [7:0] seed, input logic err);
        int nb;
        nb = (len + 63) / 64;
        for (int b = 0; b < nb; b++) begin
            exp_beat_t e;
            int rem;
            rem     = len - 64 * b;
            e       = '0;
            e.sop   = (b == 0);
            e.eop   = (rem <= 64);
            e.empty = e.eop ? 6'(64 - rem) : 6'd0;
            e.error = ERR_INJ & err & e.eop;
            for (int i = 0; i < 64; i++) begin
                if (i < rem) e.data[511-8*i -: 8] = 8'(int'(seed) + 64 * b + i);
            end
            sb.push_back(e);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = ~out_ready;
                2:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: stall stability and scoreboard comparison on accepted beats.
    initial begin : mon
        exp_beat_t prev;
        exp_beat_t cur;
        exp_beat_t e;
        bit        stalled;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
            end else begin
                cur = '{sop: out_startofpacket, eop: out_endofpacket, empty: out_empty,
                        error: out_error, data: out_data};
                if (stalled) begin
                    chk_eq("stall_valid", 512'(out_valid), 512'd1);
                    if (out_valid) begin
                        chk_eq("stall_data", cur.data, prev.data);
                        chk_eq("stall_ctrl", 512'({cur.sop, cur.eop, cur.empty, cur.error}),
                               512'({prev.sop, prev.eop, prev.empty, prev.error}));
                    end
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk_eq("unexpected_beat", 512'd1, 512'd0);
                    end else begin
                        e = sb.pop_front();
                        chk_eq("sop",   512'(cur.sop),   512'(e.sop));
                        chk_eq("eop",   512'(cur.eop),   512'(e.eop));
                        chk_eq("empty", 512'(cur.empty), 512'(e.empty));
                        chk_eq("error", 512'(cur.error), 512'(e.error));
                        chk_eq("data",  cur.data,        e.data);
                    end
                    acc_count++;
                    stalled = 1'b0;
                end else if (out_valid) begin
                    prev    = cur;
                    stalled = 1'b1;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    task automatic send_cmd(input int len, input logic [7:0] seed, input logic err);
        int t;
        if (len > 0) push_pkt(len, seed, err);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = 16'(len);
        cmd_seed  = seed;
        cmd_err   = err;
        t = 0;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk_eq("cmd_ready_wait", 512'(cmd_ready), 512'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (len > 0) begin
            @(negedge clk);
            chk_eq("busy_in_send", 512'(busy), 512'd1);
            chk_eq("ready_low_in_send", 512'(cmd_ready), 512'd0);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk_eq("drain", 512'(sb.size()), 512'd0);
        sb.delete();
        @(negedge clk);
        #1;
        chk_eq("pkt_count", 512'(pkt_count), 512'(exp_pkts));
    endtask

    initial begin : main
        int a0;
        int t;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_valid",     512'(out_valid),         512'd0);
        chk_eq("rst_cmd_ready", 512'(cmd_ready),         512'd0);
        chk_eq("rst_busy",      512'(busy),              512'd0);
        chk_eq("rst_pkt_count", 512'(pkt_count),         512'd0);
        chk_eq("rst_sop",       512'(out_startofpacket), 512'd0);
        chk_eq("rst_data",      out_data,                512'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_eq("ready_after_reset", 512'(cmd_ready), 512'd1);

        // Single full beat
        send_cmd(64, 8'h00, 1'b0);
        exp_pkts = 1;
        wait_drain();

        // One byte spill into a second beat, byte wrap
        send_cmd(65, 8'hF0, 1'b0);
        exp_pkts = 2;
        wait_drain();

        // Alternating backpressure
        ready_mode = 1;
        send_cmd(200, 8'h11, 1'b0);
        exp_pkts = 3;
        wait_drain();
        ready_mode = 0;

        // Zero-length command is dropped
        send_cmd(0, 8'h22, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk_eq("len0_valid", 512'(out_valid), 512'd0);
            chk_eq("len0_ready", 512'(cmd_ready), 512'd1);
        end
        chk_eq("len0_pkt_count", 512'(pkt_count), 512'(exp_pkts));

        // Reset after the third accepted beat of a long packet
        a0 = acc_count;
        send_cmd(1000, 8'h40, 1'b0);
        t = 0;
        while (acc_count < a0 + 3 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk_eq("third_beat_wait", 512'(acc_count >= a0 + 3), 512'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_eq("midrst_valid",     512'(out_valid), 512'd0);
        chk_eq("midrst_busy",      512'(busy),      512'd0);
        chk_eq("midrst_pkt_count", 512'(pkt_count), 512'd0);
        exp_pkts = 0;
        send_cmd(1, 8'h99, 1'b0);
        exp_pkts = 1;
        wait_drain();

        // Error flag request on a three-beat packet
        send_cmd(130, 8'hC3, 1'b1);
        exp_pkts = 2;
        wait_drain();

        // Random backpressure
        ready_mode = 2;
        send_cmd(300, 8'h80, 1'b1);
        exp_pkts = 3;
        wait_drain();
        ready_mode = 0;

        // Maximum length: 1024 beats, empty = 1 on the last
        send_cmd(65535, 8'h5A, 1'b0);
        exp_pkts = 4;
        wait_drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_avst_pkt_gen
`default_nettype wire
